upm_select_scan_ctrl: RTL and testbench

//  Sequences the one-hot address decoder across a set of enabled monitor targets.

---
 rtl/upm_select_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_upm_select_scan_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upm_select_scan_ctrl.sv
// Walks the one-hot decoder address across enabled monitor targets in ascending order:
// settle, request a measurement, wait for done or timeout, then move on to the next target.
module upm_select_scan_ctrl #(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 8,
    parameter int TO_W    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    input  logic [2**WIDTH-1:0]   enable_mask,
    input  logic [DWELL_W-1:0]    dwell_cycles,
    input  logic                  sample_done,
    output logic [WIDTH-1:0]      address,
    output logic                  meas_req,
    output logic                  busy,
    output logic                  scan_done,
    output logic                  timeout_err
);

    // state   | meaning
    // IDLE    | address 0, waiting for start
    // SEARCH  | one cycle: pick next enabled target above cur
    // SETTLE  | address held, dwell countdown
    // MEASURE | meas_req high, waiting for sample_done or timeout
    // DONE    | scan_done pulse, wrap or return to IDLE
    typedef enum logic [2:0] {
        S_IDLE, S_SEARCH, S_SETTLE, S_MEASURE, S_DONE
    } state_t;

    localparam int NT = 2**WIDTH;
    // Down-counter loaded so MEASURE lasts 2**TO_W-1 cycles before expiring.
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(2**TO_W - 2);

    state_t              state_q;
    logic [NT-1:0]       mask_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic                cont_q;
    logic [WIDTH-1:0]    cur_q;
    logic [DWELL_W-1:0]  cnt_q;
    logic [TO_W-1:0]     to_cnt_q;
    logic [WIDTH-1:0]    address_q;
    logic                meas_req_q;
    logic                busy_q;
    logic                scan_done_q;
    logic                timeout_err_q;

    logic                found_d;
    logic [WIDTH-1:0]    nxt_d;

    always_comb begin
        found_d = 1'b0;
        nxt_d   = '0;
        for (int i = NT - 1; i >= 1; i--) begin
            if (mask_q[i] && (i > int'(cur_q))) begin
                found_d = 1'b1;
                nxt_d   = WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            dwell_q       <= '0;
            cont_q        <= 1'b0;
            cur_q         <= '0;
            cnt_q         <= '0;
            to_cnt_q      <= '0;
            address_q     <= '0;
            meas_req_q    <= 1'b0;
            busy_q        <= 1'b0;
            scan_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            if (stop) begin
                state_q    <= S_IDLE;
                address_q  <= '0;
                meas_req_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            mask_q        <= {enable_mask[NT-1:1], 1'b0};
                            dwell_q       <= dwell_cycles;
                            cont_q        <= continuous;
                            timeout_err_q <= 1'b0;
                            cur_q         <= '0;
                            busy_q        <= 1'b1;
                            state_q       <= S_SEARCH;
                        end
                    end
                    S_SEARCH: begin
                        if (found_d) begin
                            address_q <= nxt_d;
                            cur_q     <= nxt_d;
                            cnt_q     <= dwell_q;
                            state_q   <= S_SETTLE;
                        end else begin
                            scan_done_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt_q == '0) begin
                            meas_req_q <= 1'b1;
                            to_cnt_q   <= TO_LOAD;
                            state_q    <= S_MEASURE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_MEASURE: begin
                        // sample_done takes priority over a coincident expiry
                        if (sample_done) begin
                            meas_req_q <= 1'b0;
                            state_q    <= S_SEARCH;
                        end else if (to_cnt_q == '0) begin
                            timeout_err_q <= 1'b1;
                            meas_req_q    <= 1'b0;
                            state_q       <= S_SEARCH;
                        end else begin
                            to_cnt_q <= to_cnt_q - 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (cont_q && (mask_q != '0)) begin
                            cur_q   <= '0;
                            state_q <= S_SEARCH;
                        end else begin
                            address_q <= '0;
                            busy_q    <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign address     = address_q;
    assign meas_req    = meas_req_q;
    assign busy        = busy_q;
    assign scan_done   = scan_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_upm_select_scan_ctrl.sv
// Bench for upm_select_scan_ctrl (TO_W=4): scoreboard of expected target addresses
// popped on every meas_req rising edge, plus per-scenario tasks.
module tb_upm_select_scan_ctrl;

    localparam int WIDTH   = 4;
    localparam int DWELL_W = 8;
    localparam int TO_W    = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              continuous = 1'b0;
    logic [15:0]       enable_mask = '0;
    logic [7:0]        dwell_cycles = '0;
    logic              sample_done;
    logic              sd_auto = 1'b0;
    logic              sd_man = 1'b0;
    logic [WIDTH-1:0]  address;
    logic              meas_req;
    logic              busy;
    logic              scan_done;
    logic              timeout_err;

    assign sample_done = sd_auto | sd_man;

    upm_select_scan_ctrl #(.WIDTH(WIDTH), .DWELL_W(DWELL_W), .TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
        .enable_mask(enable_mask), .dwell_cycles(dwell_cycles), .sample_done(sample_done),
        .address(address), .meas_req(meas_req), .busy(busy), .scan_done(scan_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int exp_settle = 1;
    int settle_cnt = 0;
    int rise_cnt = 0;
    int sd_cnt = 0;
    int nz_cnt = 0;
    bit auto_resp = 1'b0;

    // Model: targets are the set bits 1..15 of the mask, visited ascending.
    task automatic push_scan(input logic [15:0] m);
        for (int i = 1; i < 16; i++)
            if (m[i]) exp_q.push_back(i);
    endtask

    task automatic monitor();
        logic mr_prev = 1'b0;
        logic [WIDTH-1:0] a_prev = '0;
        int e;
        forever begin
            @(negedge clk);
            if (meas_req && !mr_prev) begin
                rise_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_meas_req address=%0d expected none", address);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(address) !== e) begin
                        errors++;
                        $display("FAIL target_addr got=%0d exp=%0d", address, e);
                    end
                    checks++;
                    if (settle_cnt !== exp_settle) begin
                        errors++;
                        $display("FAIL settle_cycles addr=%0d got=%0d exp=%0d", address, settle_cnt, exp_settle);
                    end
                end
            end
            if (address != a_prev) settle_cnt = meas_req ? 0 : 1;
            else if (!meas_req) settle_cnt++;
            if (scan_done) sd_cnt++;
            if (address != 0) nz_cnt++;
            mr_prev = meas_req;
            a_prev  = address;
        end
    endtask

    task automatic responder();
        int mcnt = 0;
        forever begin
            @(negedge clk);
            sd_auto = 1'b0;
            if (auto_resp && meas_req) begin
                mcnt++;
                if (mcnt == 2) sd_auto = 1'b1;
            end else begin
                mcnt = 0;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk); sd_man = 1'b1;
        @(negedge clk); sd_man = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (busy && n < bound) begin @(negedge clk); n++; end
        if (busy) ok = 1'b0;
    endtask

    task automatic wait_meas(input int bound, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (!meas_req && n < bound) begin @(negedge clk); n++; end
        if (!meas_req) ok = 1'b0;
    endtask

    task automatic setup(input logic [15:0] m, input int dw, input logic c, input bit ar);
        enable_mask  = m;
        dwell_cycles = 8'(dw);
        continuous   = c;
        auto_resp    = ar;
        exp_settle   = dw + 1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (address !== 4'd0) begin errors++; $display("FAIL reset_address got=%0d exp=0", address); end
        checks++; if (meas_req !== 1'b0) begin errors++; $display("FAIL reset_meas_req got=%b exp=0", meas_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL reset_scan_done got=%b exp=0", scan_done); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    endtask

    task automatic test_basic_scan();
        bit ok;
        int sd0 = sd_cnt;
        setup(16'h0092, 3, 1'b0, 1'b1);
        push_scan(16'h0092);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        checks++; if (address !== 4'd1) begin errors++; $display("FAIL start_latency address got=%0d exp=1", address); end
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_idle busy got=%b exp=0", busy); end
        checks++; if (sd_cnt - sd0 !== 1) begin errors++; $display("FAIL basic_scan_done got=%0d exp=1", sd_cnt - sd0); end
        checks++; if (address !== 4'd0) begin errors++; $display("FAIL basic_final_addr got=%0d exp=0", address); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL basic_targets_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_continuous();
        bit ok;
        int n = 0;
        int sd0 = sd_cnt;
        setup(16'h8002, 1, 1'b1, 1'b1);
        repeat (3) push_scan(16'h8002);
        exp_q.push_back(1);
        pulse_start();
        while (sd_cnt - sd0 < 3 && n < 400) begin @(negedge clk); n++; end
        checks++; if (sd_cnt - sd0 !== 3) begin errors++; $display("FAIL cont_passes got=%0d exp=3", sd_cnt - sd0); end
        wait_meas(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cont_wrap meas_req got=0 exp=1"); end
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        checks++; if (address !== 4'd0) begin errors++; $display("FAIL stop_address got=%0d exp=0", address); end
        checks++; if (meas_req !== 1'b0) begin errors++; $display("FAIL stop_meas_req got=%b exp=0", meas_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got=%b exp=0", busy); end
        repeat (10) @(negedge clk);
        checks++; if (sd_cnt - sd0 !== 3) begin errors++; $display("FAIL stop_scan_done got=%0d exp=3", sd_cnt - sd0); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL cont_targets_left got=%0d exp=0", exp_q.size()); end
        continuous = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        int hi = 1;
        setup(16'h0006, 0, 1'b0, 1'b0);
        push_scan(16'h0006);
        pulse_start();
        wait_meas(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_first_req meas_req got=0 exp=1"); end
        while (meas_req && hi < 100) begin @(negedge clk); if (meas_req) hi++; end
        checks++; if (hi !== 15) begin errors++; $display("FAIL to_req_cycles got=%0d exp=15", hi); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set got=%b exp=1", timeout_err); end
        wait_meas(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_second_req meas_req got=0 exp=1"); end
        pulse_done();
        wait_idle(50, ok);
        checks++; if (timeout_err !== 1'b1 || !ok) begin errors++; $display("FAIL to_err_sticky got=%b busy=%b exp=1,0", timeout_err, busy); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL to_targets_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_empty_masks();
        bit ok;
        logic [15:0] masks [2] = '{16'h0000, 16'h0001};
        for (int k = 0; k < 2; k++) begin
            int sd0 = sd_cnt;
            int r0 = rise_cnt;
            int nz0 = nz_cnt;
            setup(masks[k], 2, 1'b0, 1'b0);
            pulse_start();
            wait_idle(20, ok);
            repeat (3) @(negedge clk);
            checks++; if (!ok || sd_cnt - sd0 !== 1) begin errors++; $display("FAIL empty_scan_done mask=%h got=%0d exp=1", masks[k], sd_cnt - sd0); end
            checks++; if (rise_cnt !== r0) begin errors++; $display("FAIL empty_meas_req mask=%h got=%0d exp=0", masks[k], rise_cnt - r0); end
            checks++; if (nz_cnt !== nz0) begin errors++; $display("FAIL empty_address mask=%h nonzero_cycles=%0d exp=0", masks[k], nz_cnt - nz0); end
            checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL start_clears_err got=%b exp=0", timeout_err); end
        end
    endtask

    task automatic test_conflicts();
        bit ok;
        int sd0 = sd_cnt;
        int r0;
        setup(16'h0000, 0, 1'b0, 1'b0);
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy got=%b exp=0", busy); end
        repeat (5) @(negedge clk);
        checks++; if (sd_cnt !== sd0) begin errors++; $display("FAIL start_stop_scan got=%0d exp=0", sd_cnt - sd0); end

        r0 = rise_cnt;
        setup(16'h0002, 2, 1'b0, 1'b0);
        push_scan(16'h0002);
        pulse_start();
        wait_meas(50, ok);
        enable_mask = 16'h0004;
        pulse_start();
        pulse_done();
        wait_idle(50, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok || rise_cnt - r0 !== 1) begin errors++; $display("FAIL start_in_measure targets=%0d exp=1", rise_cnt - r0); end

        setup(16'h0002, 5, 1'b0, 1'b0);
        push_scan(16'h0002);
        pulse_start();
        @(negedge clk);
        pulse_done();
        wait_meas(50, ok);
        repeat (3) @(negedge clk);
        checks++; if (meas_req !== 1'b1) begin errors++; $display("FAIL done_in_settle meas_req got=%b exp=1", meas_req); end
        pulse_done();
        wait_idle(50, ok);

        setup(16'h0002, 0, 1'b0, 1'b0);
        push_scan(16'h0002);
        pulse_start();
        wait_meas(50, ok);
        repeat (14) @(negedge clk);
        sd_man = 1'b1;
        @(negedge clk); sd_man = 1'b0;
        checks++; if (timeout_err !== 1'b0 || meas_req !== 1'b0) begin errors++; $display("FAIL done_on_timeout err=%b req=%b exp=0,0", timeout_err, meas_req); end
        wait_idle(50, ok);
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL conflict_targets_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int r0;
        setup(16'h0006, 0, 1'b0, 1'b0);
        push_scan(16'h0006);
        pulse_start();
        wait_meas(50, ok);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (address !== 4'd0 || meas_req !== 1'b0 || busy !== 1'b0 || scan_done !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset addr=%0d req=%b busy=%b sd=%b err=%b exp all 0", address, meas_req, busy, scan_done, timeout_err);
        end
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        r0 = rise_cnt;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0 || rise_cnt !== r0 || address !== 4'd0) begin
            errors++;
            $display("FAIL reset_no_resume busy=%b reqs=%0d addr=%0d exp 0,0,0", busy, rise_cnt - r0, address);
        end
    endtask

    initial begin
        fork
            monitor();
            responder();
        join_none
        test_reset();
        test_basic_scan();
        test_continuous();
        test_timeout();
        test_empty_masks();
        test_conflicts();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
